// File: rtl/loop_addr_gen_if.sv
// Bundle of the loop_addr_gen control, config and address-beat signals.
// Beat out one cycle after start; stall holds all state and drops addr_out_valid.
interface loop_addr_gen_if #(
    parameter int ADDR_WIDTH    = 8,
    parameter int ADDR_STRIDE_W = 8,
    parameter int LOOP_ITER_W   = 16,
    parameter int NUM_LOOPS     = 8
);
    localparam int LOOP_ID_W = $clog2(NUM_LOOPS);

    logic                     start;
    logic                     stall;
    logic [ADDR_WIDTH-1:0]    base_addr;
    logic                     cfg_loop_iter_v;
    logic [LOOP_ITER_W-1:0]   cfg_loop_iter;
    logic                     cfg_addr_stride_v;
    logic [ADDR_STRIDE_W-1:0] cfg_addr_stride;
    logic [ADDR_WIDTH-1:0]    addr_out;
    logic                     addr_out_valid;
    logic [LOOP_ID_W-1:0]     loop_index;
    logic                     busy;
    logic                     done;

    modport master (
        output start, stall, base_addr, cfg_loop_iter_v, cfg_loop_iter,
               cfg_addr_stride_v, cfg_addr_stride,
        input  addr_out, addr_out_valid, loop_index, busy, done
    );

    modport slave (
        input  start, stall, base_addr, cfg_loop_iter_v, cfg_loop_iter,
               cfg_addr_stride_v, cfg_addr_stride,
        output addr_out, addr_out_valid, loop_index, busy, done
    );
endinterface

// File: rtl/loop_addr_gen.sv
// Nested-loop (odometer) address generator: first beat one cycle after start, one beat per cycle.
// stall freezes the address and every counter and suppresses addr_out_valid; no other backpressure.
module loop_addr_gen #(
    parameter int ADDR_WIDTH    = 8,
    parameter int ADDR_STRIDE_W = 8,
    parameter int LOOP_ITER_W   = 16,
    parameter int NUM_LOOPS     = 8
) (
    input  logic           clk,
    input  logic           reset,
    loop_addr_gen_if.slave bus
);
    localparam int LOOP_ID_W = $clog2(NUM_LOOPS);
    localparam int PTR_W     = $clog2(NUM_LOOPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         iter_ptr, stride_ptr, num_loops;
    logic [LOOP_ITER_W-1:0]   iter_tab   [NUM_LOOPS];
    logic [ADDR_STRIDE_W-1:0] stride_tab [NUM_LOOPS];
    logic [LOOP_ITER_W-1:0]   cnt_q      [NUM_LOOPS];
    logic [LOOP_ITER_W-1:0]   cnt_d      [NUM_LOOPS];
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]    n_ext, s_ext;
    logic [LOOP_ID_W-1:0]     adv_idx;
    logic                     carry, last_beat, beat, start_ok, cfg_ok;

    assign beat     = (state_q == RUN) && !bus.stall;
    assign start_ok = (state_q == IDLE) && bus.start;
    assign cfg_ok   = (state_q != RUN) && !start_ok;

    // Innermost active loop takes the +1; every loop that wraps gives back N*stride.
    always_comb begin
        carry   = 1'b1;
        adv_idx = '0;
        addr_d  = addr_q;
        n_ext   = '0;
        s_ext   = '0;
        for (int i = NUM_LOOPS - 1; i >= 0; i--) begin
            cnt_d[i] = cnt_q[i];
            if (PTR_W'(i) < num_loops && carry) begin
                n_ext = ADDR_WIDTH'(iter_tab[i]);
                s_ext = ADDR_WIDTH'(stride_tab[i]);
                if (cnt_q[i] == iter_tab[i]) begin
                    cnt_d[i] = '0;
                    addr_d   = addr_d - n_ext * s_ext;
                end else begin
                    cnt_d[i] = cnt_q[i] + LOOP_ITER_W'(1);
                    addr_d   = addr_d + s_ext;
                    carry    = 1'b0;
                    adv_idx  = LOOP_ID_W'(i);
                end
            end
        end
        last_beat = carry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_ptr   <= '0;
            stride_ptr <= '0;
            num_loops  <= '0;
            addr_q     <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                iter_tab[i]   <= '0;
                stride_tab[i] <= '0;
                cnt_q[i]      <= '0;
            end
        end else if (start_ok) begin
            num_loops  <= iter_ptr;
            addr_q     <= bus.base_addr;
            iter_ptr   <= '0;
            stride_ptr <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) cnt_q[i] <= '0;
        end else begin
            if (cfg_ok && bus.cfg_loop_iter_v && iter_ptr != PTR_W'(NUM_LOOPS)) begin
                iter_tab[iter_ptr[LOOP_ID_W-1:0]] <= bus.cfg_loop_iter;
                iter_ptr <= iter_ptr + PTR_W'(1);
            end
            if (cfg_ok && bus.cfg_addr_stride_v && stride_ptr != PTR_W'(NUM_LOOPS)) begin
                stride_tab[stride_ptr[LOOP_ID_W-1:0]] <= bus.cfg_addr_stride;
                stride_ptr <= stride_ptr + PTR_W'(1);
            end
            if (beat) begin
                cnt_q  <= cnt_d;
                addr_q <= addr_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (iter_ptr == '0) ? DONE : RUN;
            RUN:     if (beat && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.addr_out       = addr_q;
    assign bus.addr_out_valid = beat;
    assign bus.busy           = (state_q == RUN);
    assign bus.done           = (state_q == DONE);
    assign bus.loop_index     = (state_q != RUN) ? '0 :
                                beat ? adv_idx : LOOP_ID_W'(num_loops - PTR_W'(1));
endmodule

// File: tb/tb_loop_addr_gen.sv
// Directed bench for loop_addr_gen: expected beats queued at start, checked as the DUT emits them.
module tb_loop_addr_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    loop_addr_gen_if bus ();
    loop_addr_gen dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0] addr;
        logic [2:0] idx;
        bit         chk_idx;
    } beat_t;

    beat_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [15:0] it, input logic [7:0] st, input bit wi, input bit ws);
        bus.cfg_loop_iter     = it;
        bus.cfg_addr_stride   = st;
        bus.cfg_loop_iter_v   = wi;
        bus.cfg_addr_stride_v = ws;
        tick();
        bus.cfg_loop_iter_v   = 1'b0;
        bus.cfg_addr_stride_v = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [2:0] i, input bit c);
        beat_t e;
        e.addr = a;
        e.idx = i;
        e.chk_idx = c;
        sbq.push_back(e);
    endtask

    task automatic start_run(input logic [7:0] base);
        bus.base_addr = base;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts negedges until done, then checks the pulse is one cycle wide.
    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc = 0;
        bit seen = 0;
        repeat (200) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_cycle"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
        chk({tag, "_beats_left"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
        @(negedge clk);
        chk({tag, "_done_width"}, 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_six();
        push(8'h10, 3'd1, 1); push(8'h11, 3'd1, 1); push(8'h12, 3'd0, 1);
        push(8'h20, 3'd1, 1); push(8'h21, 3'd1, 1); push(8'h22, 3'd0, 0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.addr_out_valid === 1'b1) begin
            chk("beat_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                beat_t e;
                e = sbq.pop_front();
                chk("beat_addr", 32'(bus.addr_out), 32'(e.addr));
                if (e.chk_idx) chk("beat_loop_index", 32'(bus.loop_index), 32'(e.idx));
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.base_addr = '0;
        bus.cfg_loop_iter_v = 1'b0;
        bus.cfg_loop_iter = '0;
        bus.cfg_addr_stride_v = 1'b0;
        bus.cfg_addr_stride = '0;

        // Outputs while reset is held and right after release.
        repeat (3) tick();
        chk("rst_addr", 32'(bus.addr_out), 32'd0);
        chk("rst_valid", 32'(bus.addr_out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_index", 32'(bus.loop_index), 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_addr", 32'(bus.addr_out), 32'd0);
        chk("rel_done", 32'(bus.done), 32'd0);

        // Empty table: done one cycle after start, no beats.
        start_run(8'h55);
        wait_done("empty", 1);

        // Two-level nest.
        cfg(16'd1, 8'd16, 1, 1);
        cfg(16'd2, 8'd1, 1, 1);
        push_six();
        start_run(8'h10);
        wait_done("nest", 7);

        // Stall for three cycles after beat 0x11.
        cfg(16'd1, 8'd16, 1, 1);
        cfg(16'd2, 8'd1, 1, 1);
        push_six();
        start_run(8'h10);
        tick();
        tick();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.addr_out_valid), 32'd0);
            chk("stall_addr", 32'(bus.addr_out), 32'h12);
            chk("stall_busy", 32'(bus.busy), 32'd1);
            @(posedge clk);
            #1;
        end
        bus.stall = 1'b0;
        wait_done("stall", 5);

        // Address wraps modulo 256.
        cfg(16'd3, 8'd1, 1, 1);
        push(8'hFE, 3'd0, 1); push(8'hFF, 3'd0, 1); push(8'h00, 3'd0, 1); push(8'h01, 3'd0, 0);
        start_run(8'hFE);
        wait_done("wrap", 5);

        // start and cfg writes during RUN are ignored.
        cfg(16'd1, 8'd16, 1, 1);
        cfg(16'd2, 8'd1, 1, 1);
        push_six();
        start_run(8'h10);
        bus.start = 1'b1;
        bus.base_addr = 8'h80;
        bus.cfg_loop_iter_v = 1'b1;
        bus.cfg_loop_iter = 16'd5;
        bus.cfg_addr_stride_v = 1'b1;
        bus.cfg_addr_stride = 8'd7;
        tick();
        bus.start = 1'b0;
        bus.cfg_loop_iter_v = 1'b0;
        bus.cfg_addr_stride_v = 1'b0;
        wait_done("ignore", 6);
        // Reprogram iterations only: strides must still be {16,1}.
        cfg(16'd1, 8'd0, 1, 0);
        cfg(16'd2, 8'd0, 1, 0);
        push_six();
        start_run(8'h10);
        wait_done("table_kept", 7);

        // Reset mid-RUN aborts and clears the tables.
        cfg(16'd1, 8'd16, 1, 1);
        cfg(16'd2, 8'd1, 1, 1);
        push_six();
        start_run(8'h10);
        tick();
        reset = 1'b0;
        #1;
        sbq.delete();
        chk("abort_addr", 32'(bus.addr_out), 32'd0);
        chk("abort_valid", 32'(bus.addr_out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_index", 32'(bus.loop_index), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_done", 32'(bus.done), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("abort_idle_done", 32'(bus.done), 32'd0);
        cfg(16'd1, 8'd0, 1, 0);
        push(8'h40, 3'd0, 1); push(8'h40, 3'd0, 0);
        start_run(8'h40);
        wait_done("post_reset", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/loop_addr_gen.md
LOOP_ADDR_GEN -- requirements
Module: loop_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-002 SHALL have parameter ADDR_STRIDE_W, default 8, stride width (unsigned).
REQ-003 SHALL have parameter LOOP_ITER_W, default 16, iteration-count width.
REQ-004 SHALL have parameter NUM_LOOPS, default 8, maximum nest depth; LOOP_ID_W = $clog2(NUM_LOOPS).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 start  in  1  single-cycle start pulse.
REQ-009 stall  in  1  hold the current address and all loop state.
REQ-010 base_addr  in  ADDR_WIDTH  start address, latched on accepted start.
REQ-011 cfg_loop_iter_v  in  1  write enable for the next loop iteration entry.
REQ-012 cfg_loop_iter  in  LOOP_ITER_W  value N gives N+1 iterations.
REQ-013 cfg_addr_stride_v  in  1  write enable for the next loop stride entry.
REQ-014 cfg_addr_stride  in  ADDR_STRIDE_W  stride of that loop.
REQ-015 addr_out  out  ADDR_WIDTH  current address.
REQ-016 addr_out_valid  out  1  addr_out is a valid beat this cycle.
REQ-017 loop_index  out  LOOP_ID_W  outermost loop whose counter advances after this beat.
REQ-018 busy  out  1  high in RUN.
REQ-019 done  out  1  one-cycle completion pulse.

Function
REQ-020 SHALL keep separate iter and stride write pointers; each write fills entry[ptr] and increments ptr; entry 0 is the outermost loop.
REQ-021 SHALL ignore cfg writes while busy, and writes when ptr == NUM_LOOPS.
REQ-022 SHALL, on an accepted start, latch num_loops = iter ptr, latch base_addr, clear all loop counters, and clear both write pointers.
REQ-023 SHALL accept start only in IDLE; start while busy is ignored.
REQ-024 The state machine SHALL have states IDLE, RUN and DONE.
REQ-025 IDLE->RUN on start with num_loops>0; IDLE->DONE on start with num_loops==0.
REQ-026 RUN->DONE after the final beat; DONE->IDLE unconditionally; done=1 only in DONE.
REQ-027 The first beat SHALL appear in the cycle after start (addr_out = base_addr).
REQ-028 Each RUN cycle with stall=0 SHALL be one beat: addr_out_valid=1 and the odometer advances.
REQ-029 Odometer advance: the innermost counter increments; a counter that has reached its N wraps to 0 and carries outward.
REQ-030 Address SHALL equal base + sum(counter_i * stride_i), maintained incrementally: add stride_i on increment of loop i, subtract N_i*stride_i on its wrap.
REQ-031 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; strides are zero-extended.
REQ-032 Unprogrammed stride entries SHALL read 0.
REQ-033 The final beat is the one where every counter equals its N.
REQ-034 With stall=1 in RUN: addr_out_valid=0, addr_out and counters hold; stall in IDLE or DONE has no effect.
REQ-035 loop_index SHALL equal the outermost carrying loop on a beat, else num_loops-1; it is 0 outside RUN.
REQ-036 Total beats SHALL equal product(N_i+1).

Reset
REQ-037 On reset low: state=IDLE, all counters, pointers, table entries and addr_out = 0, addr_out_valid=0, busy=0, done=0, loop_index=0.
REQ-038 Reset asserted mid-RUN SHALL abort with no done pulse; a new start after release behaves as a fresh start with no table programmed.

Verification
REQ-039 Reset release -> all outputs 0; start with nothing programmed -> done=1 exactly one cycle later, no beats.
REQ-040 iter {1,2}, stride {16,1}, base 0x10, start -> beats 0x10,0x11,0x12,0x20,0x21,0x22 on consecutive cycles; done the cycle after 0x22.
REQ-041 Same configuration as REQ-040 with stall high for 3 cycles after beat 0x11 -> addr_out holds 0x12 with valid=0 during the stall, then the sequence resumes unchanged.
REQ-042 iter {3}, stride {1}, base 0xFE -> beats 0xFE,0xFF,0x00,0x01 (wrap), then done.
REQ-043 start and cfg writes during RUN -> ignored; sequence and table unchanged.
REQ-044 Reset pulled low mid-RUN -> outputs 0 immediately, no done pulse.
